sort_drain_scheduler: RTL and testbench

SORT_DRAIN_SCHEDULER -- requirements
Module: sort_drain_scheduler

---
 rtl/sorter_pkg.sv | 25 ++
 rtl/drain_arb.sv | 44 ++++
 rtl/sort_drain_scheduler.sv | 164 ++++++++++++++++
 tb/tb_sort_drain_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sorter_pkg
// Description : Shared types and constants for the sort drain scheduler:
//               FSM state encoding, FIFO source identifiers and the default
//               data width.
// Revision    : 1.0 - initial release
// ============================================================================
package sorter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Source identifiers, also used as grant / out_src encoding
  localparam logic SRC_VAL  = 1'b0;
  localparam logic SRC_IVAL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CAPT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage : sorter_pkg
`default_nettype wire

// File: rtl/drain_arb.sv
`default_nettype none
// ============================================================================
// Module      : drain_arb
// Description : Two-way grant logic between the valid-class and the
//               invalid-class FIFO. Round-robin by default; strict priority
//               for the valid-class FIFO when DRAIN_STRICT_PRIO_EN is defined
//               (the last-served input then does not exist).
// Ports       : i_last       - source served last (round-robin build only)
//               i_val_empty  - valid-class FIFO empty flag
//               i_ival_empty - invalid-class FIFO empty flag
//               o_any        - at least one FIFO is non-empty
//               o_grant      - granted source (SRC_VAL / SRC_IVAL)
// Macros      : DRAIN_STRICT_PRIO_EN
// Revision    : 1.0 - initial release
// ============================================================================
module drain_arb
  import sorter_pkg::*;
(
`ifndef DRAIN_STRICT_PRIO_EN
  input  logic i_last,
`endif
  input  logic i_val_empty,
  input  logic i_ival_empty,
  output logic o_any,
  output logic o_grant
);

  always_comb begin
    o_any = !i_val_empty || !i_ival_empty;
`ifdef DRAIN_STRICT_PRIO_EN
    // Valid-class FIFO wins whenever it has data
    o_grant = i_val_empty ? SRC_IVAL : SRC_VAL;
`else
    if (!i_val_empty && !i_ival_empty) begin
      // Tie: hand the grant to the source that was not served last
      o_grant = ~i_last;
    end else begin
      o_grant = i_val_empty ? SRC_IVAL : SRC_VAL;
    end
`endif
  end

endmodule : drain_arb
`default_nettype wire

// File: rtl/sort_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sort_drain_scheduler
// Description : Drains words from two sorter FIFOs (valid / invalid class)
//               one at a time into a ready/valid output stream, tagging each
//               word with its source and counting accepted words per source.
//               Each word walks IDLE -> READ -> CAPT -> OUT (>= 4 cycles).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               drain_en            - drain permission, sampled in IDLE
//               val_empty/rd_en/rdata   - valid-class FIFO read port
//               ival_empty/rd_en/rdata  - invalid-class FIFO read port
//               out_valid/ready/data/src - output stream
//               val_drained, ival_drained - per-source accepted counters
//               busy                - high whenever not IDLE
// Macros      : DRAIN_STRICT_PRIO_EN - strict priority for the val FIFO
//               instead of round-robin
// Revision    : 1.0 - initial release
// ============================================================================
module sort_drain_scheduler
  import sorter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drain_en,
  input  logic             val_empty,
  output logic             val_rd_en,
  input  logic [WIDTH-1:0] val_rdata,
  input  logic             ival_empty,
  output logic             ival_rd_en,
  input  logic [WIDTH-1:0] ival_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] val_drained,
  output logic [CNT_W-1:0] ival_drained,
  output logic             busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_grant;
  logic [WIDTH-1:0]  r_data;
  logic              r_src;
  logic [CNT_W-1:0]  r_val_cnt;
  logic [CNT_W-1:0]  r_ival_cnt;

  logic              w_any;
  logic              w_grant;
  logic              w_take_grant;
  logic              w_capture;
  logic              w_hs;

`ifndef DRAIN_STRICT_PRIO_EN
  logic              r_last;
`endif

  drain_arb u_arb (
`ifndef DRAIN_STRICT_PRIO_EN
    .i_last       (r_last),
`endif
    .i_val_empty  (val_empty),
    .i_ival_empty (ival_empty),
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_take_grant = 1'b0;
    w_capture    = 1'b0;
    w_hs         = 1'b0;
    val_rd_en    = 1'b0;
    ival_rd_en   = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;

    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        // Empty flags only matter here; the grant is frozen for the transfer
        if (drain_en && w_any) begin
          w_take_grant = 1'b1;
          w_state_nxt  = ST_READ;
        end
      end
      ST_READ: begin
        val_rd_en   = (r_grant == SRC_VAL);
        ival_rd_en  = (r_grant == SRC_IVAL);
        w_state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        // FIFO read data is valid the cycle after the strobe
        w_capture   = 1'b1;
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, datapath and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= SRC_VAL;
      r_data     <= '0;
      r_src      <= SRC_VAL;
      r_val_cnt  <= '0;
      r_ival_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_grant) begin
        r_grant <= w_grant;
      end
      if (w_capture) begin
        r_data <= (r_grant == SRC_IVAL) ? ival_rdata : val_rdata;
        r_src  <= r_grant;
      end
      if (w_hs) begin
        if (r_src == SRC_VAL) begin
          r_val_cnt <= r_val_cnt + CNT_W'(1);
        end else begin
          r_ival_cnt <= r_ival_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifndef DRAIN_STRICT_PRIO_EN
  // Last-served pointer moves on the handshake only; reset value makes the
  // invalid-class FIFO win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= SRC_VAL;
    end else if (w_hs) begin
      r_last <= r_src;
    end
  end
`endif

  assign out_data     = r_data;
  assign out_src      = r_src;
  assign val_drained  = r_val_cnt;
  assign ival_drained = r_ival_cnt;

endmodule : sort_drain_scheduler
`default_nettype wire

// File: tb/tb_sort_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_drain_scheduler
// Description : Directed self-checking bench for sort_drain_scheduler with
//               queue-based FIFO models. Counters are built 4 bits wide so
//               the wrap case is reachable with real handshakes.
// Macros      : DRAIN_STRICT_PRIO_EN selects the strict-priority expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_drain_scheduler;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             drain_en;
  logic             val_empty;
  logic             val_rd_en;
  logic [WIDTH-1:0] val_rdata;
  logic             ival_empty;
  logic             ival_rd_en;
  logic [WIDTH-1:0] ival_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic [CNT_W-1:0] val_drained;
  logic [CNT_W-1:0] ival_drained;
  logic             busy;

  always #5 clk = ~clk;

  sort_drain_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .drain_en     (drain_en),
    .val_empty    (val_empty),
    .val_rd_en    (val_rd_en),
    .val_rdata    (val_rdata),
    .ival_empty   (ival_empty),
    .ival_rd_en   (ival_rd_en),
    .ival_rdata   (ival_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_src      (out_src),
    .val_drained  (val_drained),
    .ival_drained (ival_drained),
    .busy         (busy)
  );

  int               n_chk = 0;
  int               n_bad = 0;
  int               cyc = 0;
  int               rd_pulses = 0;
  logic [WIDTH-1:0] vq[$];
  logic [WIDTH-1:0] iq[$];
  int               hs_src[$];
  int               hs_data[$];
  int               hs_cyc[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic upd_empty();
    val_empty  = (vq.size() == 0);
    ival_empty = (iq.size() == 0);
  endtask

  // One clock: sample DUT, advance past the edge, then model the FIFOs
  task automatic tick();
    logic       s_v, s_i, s_hs, s_src;
    logic [7:0] s_d;
    s_v   = val_rd_en;
    s_i   = ival_rd_en;
    s_hs  = out_valid && out_ready;
    s_src = out_src;
    s_d   = out_data;
    if (s_v || s_i) begin
      chk("rd_exclusive", 32'(s_v && s_i), 32'd0);
      if (s_v) chk("rd_val_nonempty", 32'(vq.size() > 0), 32'd1);
      if (s_i) chk("rd_ival_nonempty", 32'(iq.size() > 0), 32'd1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_v) begin
      rd_pulses++;
      if (vq.size() > 0) val_rdata = vq.pop_front();
    end
    if (s_i) begin
      rd_pulses++;
      if (iq.size() > 0) ival_rdata = iq.pop_front();
    end
    if (s_hs) begin
      hs_src.push_back(int'(s_src));
      hs_data.push_back(int'(s_d));
      hs_cyc.push_back(cyc);
    end
    upd_empty();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    hs_src.delete();
    hs_data.delete();
    hs_cyc.delete();
    rd_pulses = 0;
  endtask

  int exp_src[4];
  int exp_dat[4];
  int n;
  int rd0;

  initial begin
    rst        = 1'b1;
    drain_en   = 1'b0;
    out_ready  = 1'b0;
    val_rdata  = '0;
    ival_rdata = '0;
    vq.push_back(8'hA5);
    vq.push_back(8'hA5);
    iq.push_back(8'h00);
    iq.push_back(8'h00);
    upd_empty();
    @(posedge clk);
    #1;

    // ---- Reset with both FIFOs loaded, drain disabled ----
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("rst_rd_pulses", rd_pulses, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_val_cnt", 32'(val_drained), 0);
    chk("rst_ival_cnt", 32'(ival_drained), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);

    // ---- Alternating drain, out_ready high ----
`ifdef DRAIN_STRICT_PRIO_EN
    exp_src = '{0, 0, 1, 1};
    exp_dat = '{32'hA5, 32'hA5, 0, 0};
`else
    exp_src = '{1, 0, 1, 0};
    exp_dat = '{0, 32'hA5, 0, 32'hA5};
`endif
    out_ready = 1'b1;
    drain_en  = 1'b1;
    n = 0;
    while (hs_src.size() < 4 && n < 60) begin
      tick();
      n++;
    end
    chk("seq_words", hs_src.size(), 4);
    for (int k = 0; k < hs_src.size() && k < 4; k++) begin
      chk($sformatf("seq_src%0d", k), hs_src[k], exp_src[k]);
      chk($sformatf("seq_data%0d", k), hs_data[k], exp_dat[k]);
      if (k > 0) chk($sformatf("seq_gap%0d", k), hs_cyc[k] - hs_cyc[k-1], 4);
    end
    for (int k = 0; k < 4; k++) tick();
    chk("seq_no_extra", hs_src.size(), 4);
    chk("seq_val_cnt", 32'(val_drained), 2);
    chk("seq_ival_cnt", 32'(ival_drained), 2);
    chk("seq_idle", 32'(busy), 0);

    // ---- Back-pressure in OUT, drain_en dropped mid-transfer ----
    drain_en  = 1'b0;
    out_ready = 1'b0;
    do_reset();
    vq.push_back(8'h3C);
    upd_empty();
    drain_en = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("bp_reach_out", 32'(out_valid), 1);
    drain_en = 1'b0;
    rd0 = rd_pulses;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_cnt", 32'(val_drained), 0);
    end
    chk("bp_no_rd", rd_pulses, rd0);
    chk("bp_src", 32'(out_src), 0);
    out_ready = 1'b1;
    tick();
    chk("bp_cnt_after", 32'(val_drained), 1);
    chk("bp_valid_after", 32'(out_valid), 0);
    chk("bp_busy_after", 32'(busy), 0);

    // ---- Reset while in CAPT discards the word ----
    do_reset();
    iq.push_back(8'h77);
    upd_empty();
    drain_en = 1'b1;
    n = 0;
    while (!ival_rd_en && n < 10) begin
      tick();
      n++;
    end
    chk("capt_read_seen", 32'(ival_rd_en), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("capt_busy", 32'(busy), 0);
    chk("capt_valid", 32'(out_valid), 0);
    chk("capt_ival_cnt", 32'(ival_drained), 0);
    chk("capt_data", 32'(out_data), 0);
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("capt_no_hs", hs_src.size(), 0);
    chk("capt_ival_cnt2", 32'(ival_drained), 0);

    // ---- Counter wrap ----
    do_reset();
    for (int k = 0; k < 16; k++) vq.push_back(8'(k + 8'h10));
    upd_empty();
    drain_en = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (hs_src.size() < 15 && n < 100) begin
      tick();
      n++;
    end
    chk("wrap_pre_words", hs_src.size(), 15);
    chk("wrap_pre_cnt", 32'(val_drained), 32'hF);
    n = 0;
    while (hs_src.size() < 16 && n < 10) begin
      tick();
      n++;
    end
    chk("wrap_words", hs_src.size(), 16);
    chk("wrap_cnt", 32'(val_drained), 0);
    chk("wrap_ival_cnt", 32'(ival_drained), 0);
    if (hs_data.size() == 16) chk("wrap_last_data", hs_data[15], 32'h1F);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_sort_drain_scheduler
`default_nettype wire
